// File: rtl/rbm_fwd_core.sv
// RBM forward pass: streams I_DIM visible values against per-lane weights, accumulates with
// saturation, then emits either a piecewise-linear sigmoid or the raw Q4.12 preactivation.
module rbm_fwd_core #(
  parameter int unsigned I_DIM   = 256,
  parameter int unsigned H_LANES = 4,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned SHIFT   = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       mode,
  input  logic [H_LANES*ACC_W-1:0]   bias,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 v_data,
  input  logic [H_LANES*16-1:0]      w_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [H_LANES*16-1:0]      out_data,
  output logic                       busy
);

  localparam int unsigned CNT_W = $clog2(I_DIM + 1);
  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(I_DIM - 1);
  localparam logic signed [ACC_W-1:0] XMax = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] XMin = -XMax;
  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAcc, StAct, StOut} state_e;

  state_e                    state_q;
  logic signed [ACC_W-1:0]   acc_q [H_LANES];
  logic [CNT_W-1:0]          cnt_q;
  logic                      mode_q;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic                      busy_q;
  logic [H_LANES*16-1:0]     out_data_q;

  logic signed [ACC_W-1:0]   acc_nxt [H_LANES];
  logic [15:0]               res     [H_LANES];

  for (genvar k = 0; k < H_LANES; k++) begin : g_lane
    logic signed [15:0]      w_k;
    logic signed [23:0]      prod;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] shr;
    logic signed [ACC_W-1:0] xc;
    logic signed [15:0]      x16;
    logic [15:0]             a;
    logic [16:0]             y_pos;
    logic [16:0]             y_neg;
    logic [15:0]             sig;

    assign w_k  = w_data[16*k +: 16];
    assign prod = $signed({{16{v_data[7]}}, v_data}) * $signed({{8{w_k[15]}}, w_k});
    // One guard bit is enough: a single product can never overflow by more than one bit.
    assign sum  = $signed({acc_q[k][ACC_W-1], acc_q[k]})
                + $signed({{(ACC_W-23){prod[23]}}, prod});

    always_comb begin
      acc_nxt[k] = sum[ACC_W-1:0];
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        acc_nxt[k] = sum[ACC_W] ? AccMin : AccMax;
      end
    end

    assign shr = acc_q[k] >>> SHIFT;

    always_comb begin
      xc = shr;
      if (shr > XMax) begin
        xc = XMax;
      end else if (shr < XMin) begin
        xc = XMin;
      end
    end

    assign x16 = xc[15:0];
    assign a   = x16[15] ? 16'(-x16) : x16;

    always_comb begin
      if (a < 16'h1000) begin
        y_pos = 17'h08000 + {a[14:0], 2'b00};
      end else if (a < 16'h2600) begin
        y_pos = 17'h0A000 + {a, 1'b0};
      end else if (a < 16'h5000) begin
        y_pos = 17'h0D800 + {2'b00, a[15:1]};
      end else begin
        y_pos = 17'h10000;
      end
    end

    // Negative inputs use the symmetry sigmoid(-x) = 1 - sigmoid(x).
    assign y_neg = 17'h10000 - y_pos;

    always_comb begin
      if (!x16[15]) begin
        sig = y_pos[16] ? 16'hFFFF : y_pos[15:0];
      end else begin
        sig = y_neg[15:0];
      end
    end

    assign res[k] = mode_q ? x16 : sig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < H_LANES; k++) begin
        acc_q[k] <= '0;
      end
    end else if (clear) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int k = 0; k < H_LANES; k++) begin
              acc_q[k] <= bias[ACC_W*k +: ACC_W];
            end
            mode_q     <= mode;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StAcc;
          end
        end
        StAcc: begin
          if (in_valid && in_ready_q) begin
            for (int k = 0; k < H_LANES; k++) begin
              acc_q[k] <= acc_nxt[k];
            end
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LastBeat) begin
              in_ready_q <= 1'b0;
              state_q    <= StAct;
            end
          end
        end
        StAct: begin
          for (int k = 0; k < H_LANES; k++) begin
            out_data_q[16*k +: 16] <= res[k];
          end
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_rbm_fwd_core.sv
// Scoreboard bench for rbm_fwd_core: directed corner frames plus randomized frames checked
// against an arithmetic reference model of the forward pass.
module tb_rbm_fwd_core;

  localparam int I_DIM = 4;
  localparam int H     = 2;
  localparam int ACC_W = 32;
  localparam int SHIFT = 10;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               clear = 1'b0;
  logic               mode = 1'b0;
  logic [H*ACC_W-1:0] bias = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [7:0]         v_data = '0;
  logic [H*16-1:0]    w_data = '0;
  logic               out_valid;
  logic               out_ready;
  logic [H*16-1:0]    out_data;
  logic               busy;

  logic out_ready_dir = 1'b1;
  logic out_ready_rnd = 1'b0;
  logic rand_ready = 1'b0;
  assign out_ready = rand_ready ? out_ready_rnd : out_ready_dir;

  rbm_fwd_core #(
    .I_DIM  (I_DIM),
    .H_LANES(H),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clear    (clear),
    .mode     (mode),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .v_data   (v_data),
    .w_data   (w_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int t_start = 0;
  logic [H*16-1:0] exp_q[$];
  logic [H*16-1:0] mon_exp;

  // Current frame description
  int     fv[I_DIM];
  int     fw[I_DIM][H];
  longint fb[H];
  bit     fm;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer dot product with per-beat clamping, floor divide by 2^SHIFT,
  // then the piecewise sigmoid table in plain arithmetic.
  function automatic logic [15:0] model_lane(input int k);
    longint acc, x, a, y, div;
    acc = fb[k];
    for (int i = 0; i < I_DIM; i++) begin
      acc = acc + longint'(fv[i]) * longint'(fw[i][k]);
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    end
    div = longint'(1) << SHIFT;
    x = acc / div;
    if (acc < 0 && (acc % div) != 0) x = x - 1;
    if (x > 32767) x = 32767;
    if (x < -32767) x = -32767;
    if (fm) return 16'(x);
    a = (x < 0) ? -x : x;
    if (a < 4096)       y = 32768 + 4 * a;
    else if (a < 9728)  y = 40960 + 2 * a;
    else if (a < 20480) y = 55296 + a / 2;
    else                y = 65536;
    if (x >= 0) return (y > 65535) ? 16'hFFFF : 16'(y);
    return 16'(65536 - y);
  endfunction

  function automatic logic [H*16-1:0] model_word();
    logic [H*16-1:0] r;
    for (int k = 0; k < H; k++) r[16*k +: 16] = model_lane(k);
    return r;
  endfunction

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got 0x%0h with no result pending", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", longint'(out_data), longint'(mon_exp));
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready_rnd = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input bit push);
    for (int k = 0; k < H; k++) bias[ACC_W*k +: ACC_W] = fb[k][31:0];
    mode = fm;
    if (push) exp_q.push_back(model_word());
    start = 1'b1;
    t_start = cyc;
    tick();
    start = 1'b0;
  endtask

  // stall_mode 0: no gaps, 1: one gap between beats, 2: random gaps
  task automatic send_beats(input int stall_mode, input int n_beats);
    int g;
    int ns;
    for (int i = 0; i < n_beats; i++) begin
      ns = (stall_mode == 1 && i > 0) ? 1 : (stall_mode == 2) ? $urandom_range(0, 2) : 0;
      in_valid = 1'b0;
      for (int s = 0; s < ns; s++) tick();
      in_valid = 1'b1;
      v_data = 8'(fv[i]);
      for (int k = 0; k < H; k++) w_data[16*k +: 16] = 16'(fw[i][k]);
      g = 0;
      while (!in_ready && g < 20) begin
        tick();
        g++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int g = 0;
    while (!out_valid && g < 50) begin
      tick();
      g++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
    lat = cyc - t_start;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 300) begin
      tick();
      g++;
    end
    check("idle_reached", longint'(busy), 0);
  endtask

  task automatic do_frame(input int stall_mode, output int lat, output logic [H*16-1:0] data);
    start_frame(1'b1);
    send_beats(stall_mode, I_DIM);
    wait_out(lat);
    data = out_data;
  endtask

  task automatic set_uniform(input int v, input int w0, input int w1, input longint b,
                             input bit m);
    for (int i = 0; i < I_DIM; i++) begin
      fv[i] = v;
      fw[i][0] = w0;
      fw[i][1] = w1;
    end
    fb[0] = b;
    fb[1] = b;
    fm = m;
  endtask

  task automatic expect_no_output(input string name);
    int seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    int lat;
    logic [H*16-1:0] d;
    logic [H*16-1:0] d0;
    int r;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Half times half, opposite-signed lanes
    set_uniform(64, 16384, -16384, 0, 1'b0);
    do_frame(0, lat, d);
    check("basic_latency", lat, I_DIM + 2);
    check("basic_data", d, 32'h4000_C000);
    check("basic_in_ready_out", in_ready, 0);
    wait_idle();

    // Zero weights in both modes
    set_uniform(93, 0, 0, 0, 1'b0);
    do_frame(0, lat, d);
    check("zero_sig", d, 32'h8000_8000);
    wait_idle();
    set_uniform(93, 0, 0, 0, 1'b1);
    do_frame(0, lat, d);
    check("zero_raw", d, 32'h0000_0000);
    wait_idle();

    // Saturation at both accumulator limits
    set_uniform(127, 32767, 32767, 64'sh7FFF_FF00, 1'b0);
    do_frame(0, lat, d);
    check("sat_pos_sig", d, 32'hFFFF_FFFF);
    wait_idle();
    set_uniform(127, 32767, 32767, 64'sh7FFF_FF00, 1'b1);
    do_frame(0, lat, d);
    check("sat_pos_raw", d, 32'h7FFF_7FFF);
    wait_idle();
    set_uniform(127, -32767, -32767, -64'sd2147483392, 1'b0);
    do_frame(0, lat, d);
    check("sat_neg_sig", d, 32'h0000_0000);
    wait_idle();
    set_uniform(127, -32767, -32767, -64'sd2147483392, 1'b1);
    do_frame(0, lat, d);
    check("sat_neg_raw", d, 32'h8001_8001);
    wait_idle();

    // Gapped input: each idle cycle between beats adds one cycle of latency
    set_uniform(64, 16384, -16384, 0, 1'b0);
    do_frame(1, lat, d);
    check("gap_latency", lat, I_DIM + 2 + (I_DIM - 1));
    check("gap_data", d, 32'h4000_C000);
    wait_idle();

    // Back-pressure in OUT with an ignored start pulse
    out_ready_dir = 1'b0;
    set_uniform(-100, 12345, -23456, 64'sd3000, 1'b0);
    do_frame(0, lat, d0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) start = 1'b1;
      tick();
      start = 1'b0;
      check("hold_data", out_data, d0);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready_dir = 1'b1;
    tick();
    check("release_valid", out_valid, 0);
    check("release_busy", busy, 0);

    // Clear after two beats
    set_uniform(50, 1000, 2000, 0, 1'b0);
    start_frame(1'b0);
    send_beats(0, 2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_busy", busy, 0);
    check("clear_in_ready", in_ready, 0);
    expect_no_output("clear_no_out");

    // start together with clear in IDLE
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check("start_clear_idle", busy, 0);

    // Asynchronous reset in the middle of accumulation
    start_frame(1'b0);
    send_beats(0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_output("arst_no_out");
    check("arst_idle", busy, 0);

    // Randomized frames with random gaps and random back-pressure
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      fm = 1'($urandom_range(0, 1));
      for (int k = 0; k < H; k++) begin
        r = int'($urandom());
        fb[k] = longint'(r) >>> $urandom_range(2, 12);
      end
      for (int i = 0; i < I_DIM; i++) begin
        fv[i] = int'($urandom_range(0, 255)) - 128;
        for (int k = 0; k < H; k++) fw[i][k] = int'($urandom_range(0, 65535)) - 32768;
      end
      start_frame(1'b1);
      send_beats(2, I_DIM);
      wait_idle();
    end
    rand_ready = 1'b0;
    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
